// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Registers the execute-stage outputs, issues loads/stores to the data memory over a
// req/ack handshake, passes ALU results straight through, and emits one write-back
// record per retired instruction. Upstream is stalled while an access is outstanding.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   ex_valid/ex_ready          execute-stage handshake
//   ex_op, ex_wreg, ex_wren    opcode, destination register, active-low byte enables
//   ex_result, ex_addr         ALU result / store data, word address
//   flush                      kill incoming and in-flight instruction
//   dmem_*                     data-memory request channel
//   wb_valid/we/reg/data       write-back record (wb_valid is a one-cycle pulse)
module mem_stage #(
  parameter bit HALF_SEXT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_op,
  input  logic [4:0]  ex_wreg,
  input  logic [3:0]  ex_wren,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_addr,
  input  logic        flush,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we_n,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  localparam logic [5:0] OpLw = 6'd16;
  localparam logic [5:0] OpLh = 6'd18;
  localparam logic [5:0] OpLb = 6'd20;
  localparam logic [3:0] WeNone = 4'b1111;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q;
  logic        kill_q;
  logic [5:0]  ld_op_q;
  logic [4:0]  wreg_q;
  logic        store_q;

  logic        is_load;
  logic        is_store;
  logic [31:0] load_data;

  assign is_load  = (ex_op == OpLw) || (ex_op == OpLh) || (ex_op == OpLb);
  // Stores are recognised by their byte enables, not by opcode.
  assign is_store = (ex_wren != WeNone);

  // Never depends on dmem_ack so the upstream stall has no combinational path to memory.
  assign ex_ready = (state_q == StIdle);

  always_comb begin
    load_data = dmem_rdata;
    case (ld_op_q)
      OpLh:    load_data = {{16{HALF_SEXT & dmem_rdata[15]}}, dmem_rdata[15:0]};
      OpLb:    load_data = {{24{HALF_SEXT & dmem_rdata[7]}}, dmem_rdata[7:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      kill_q     <= 1'b0;
      ld_op_q    <= 6'd0;
      wreg_q     <= 5'd0;
      store_q    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_we_n  <= WeNone;
      dmem_wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_reg     <= 5'd0;
      wb_data    <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ex_valid && !flush) begin
            if (is_load || is_store) begin
              state_q    <= StAccess;
              kill_q     <= 1'b0;
              ld_op_q    <= ex_op;
              wreg_q     <= ex_wreg;
              store_q    <= is_store;
              dmem_req   <= 1'b1;
              dmem_addr  <= ex_addr;
              dmem_wdata <= ex_result;
              dmem_we_n  <= is_store ? ex_wren : WeNone;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_wreg != 5'd0);
              wb_reg   <= ex_wreg;
              wb_data  <= ex_result;
            end
          end
        end
        StAccess: begin
          if (dmem_ack) begin
            state_q   <= StIdle;
            kill_q    <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we_n <= WeNone;
            // A flush arriving together with the ack still drops the result.
            if (!kill_q && !flush) begin
              wb_valid <= 1'b1;
              if (store_q) begin
                wb_we   <= 1'b0;
                wb_reg  <= 5'd0;
                wb_data <= 32'd0;
              end else begin
                wb_we   <= (wreg_q != 5'd0);
                wb_reg  <= wreg_q;
                wb_data <= load_data;
              end
            end
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline, directly downstream of the execute-stage ALU. It registers the ALU outputs (operation, destination register, byte write-enable, result) plus a separately computed memory address. Loads and stores go to the data memory over a req/ack handshake; all other operations pass straight through. It presents one write-back record per retired instruction to the register-file write stage and stalls the upstream stage while a memory access is outstanding.

## Interface
Parameters:
- `HALF_SEXT`, default 0: 1 = sign-extend half/byte loads; 0 = zero-extend.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  execute stage presents an instruction this cycle.
- `ex_ready`  out  1  stage can accept; transfer occurs when `ex_valid && ex_ready`.
- `ex_op`  in  6  primary opcode.
- `ex_wreg`  in  5  destination register (0 = no write).
- `ex_wren`  in  4  active-low byte write-enable: 0000 word, 1100 half, 1110 byte, 1111 no write.
- `ex_result`  in  32  ALU result; store data for stores.
- `ex_addr`  in  32  word address for loads/stores.
- `flush`  in  1  kill the incoming instruction and any in-flight one.
- `dmem_req`  out  1  memory request, held until acknowledged.
- `dmem_addr`  out  32  word address.
- `dmem_we_n`  out  4  active-low byte enables; 1111 = read.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  read data, valid when `dmem_ack`=1.
- `dmem_ack`  in  1  access complete.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `wb_we`  out  1  register write required.
- `wb_reg`  out  5  destination register.
- `wb_data`  out  32  write-back value.

## Operation
- Memory ops:
  - loads: op 16 (word), 18 (half, bits 15:0), 20 (byte, bits 7:0).
  - stores: op 24/26/28, identified by `ex_wren` != 1111.
  - All other opcodes are ALU ops.
- FSM states:
  - IDLE: `ex_ready`=1.
  - ACCESS: `ex_ready`=0, `dmem_req`=1.
- IDLE, accepted non-memory op:
  - next cycle `wb_valid`=1, `wb_reg`=`ex_wreg`, `wb_data`=`ex_result`, `wb_we`=(`ex_wreg`!=0).
  - FSM stays IDLE, so back-to-back ALU ops retire one per cycle.
- IDLE, accepted memory op:
  - register `dmem_addr`=`ex_addr`, `dmem_wdata`=`ex_result`.
  - `dmem_we_n`=`ex_wren` for stores, 1111 for loads.
  - go to ACCESS.
- ACCESS: address, data and enables are held stable until `dmem_ack` is sampled high. On that edge:
  - `dmem_req` drops and `dmem_we_n` returns to 1111.
  - next cycle `wb_valid`=1 and the FSM returns to IDLE.
- Load write-back data: rdata extracted per op (word / [15:0] / [7:0]), extended per `HALF_SEXT`; `wb_we`=(`wreg`!=0).
- Store write-back: `wb_we`=0, `wb_reg`=0, `wb_data`=0.
- A new instruction may be accepted in the cycle the FSM is back in IDLE.
- `flush`:
  - In IDLE it blocks acceptance: no `wb_valid`, no request.
  - In ACCESS it sets a kill flag. The request is not aborted; the stage still waits for `dmem_ack`, then returns to IDLE with no `wb_valid`. The kill flag clears on leaving ACCESS.
- `wb_valid` is never asserted for a killed instruction.

## Timing
- Reset (async, immediate): state IDLE, kill flag 0, `dmem_req`=0, `dmem_we_n`=1111, `dmem_addr`=0, `dmem_wdata`=0, `wb_valid`=0, `wb_we`=0, `wb_reg`=0, `wb_data`=0.
- All outputs except `ex_ready` are registered. `ex_ready` is decoded from state only, never from `dmem_ack`.
- ALU op latency: accept at edge N, `wb_valid` during cycle N+1.
- Memory op latency:
  - accept at edge N; `dmem_req` high from cycle N+1.
  - ack sampled at edge M (M ≥ N+1); `wb_valid` during cycle M+1; `ex_ready`=1 during cycle M+1.
  - If `dmem_ack` is high in the first request cycle, total latency is 2 cycles.
- `dmem_ack` while `dmem_req`=0 is ignored.
- Reset mid-ACCESS drops the request immediately; the memory side must tolerate this abandonment.
- `flush` and `dmem_ack` in the same ACCESS cycle: the access completes and the result is dropped.

## Test plan
- ALU stream: three back-to-back ALU ops with `wreg` 5/6/0 and results 1/2/3 → `wb_valid` on 3 consecutive cycles; `wb_we` 1,1,0; `ex_ready` stays 1.
- Load word, `ex_addr`=0x40, ack after 3 wait cycles, rdata 0xDEADBEEF, `wreg`=7 → `dmem_req` high 4 cycles with `dmem_we_n`=1111, `ex_ready` low throughout, then `wb_data`=0xDEADBEEF, `wb_reg`=7.
- Byte and half loads, rdata 0x1234_80F0: op 20 → `wb_data`=0xF0 (`HALF_SEXT`=0) or 0xFFFF_FFF0 (`HALF_SEXT`=1); op 18 → 0x80F0 or 0xFFFF_80F0.
- Store half, `ex_wren`=1100, data 0xAABBCCDD, immediate ack → `dmem_we_n`=1100 for one cycle, `dmem_wdata`=0xAABBCCDD, `wb_valid`=1 with `wb_we`=0, then back to IDLE.
- Flush: `flush` during a 2-cycle-wait load → request held until ack, no `wb_valid`; a following ALU op retires normally. Also `flush` with `ex_valid` in IDLE → nothing retires.
- Async reset asserted mid-ACCESS → `dmem_req`=0, `dmem_we_n`=1111, `wb_valid`=0 immediately; after release `ex_ready`=1.
